instr_fetch: RTL and testbench

Program-counter and instruction-fetch stage sitting directly upstream of the control decoder. Holds the PC, drives the synchronous instruction ROM address, presents the 9-bit machine word and its valid flag to the decoder, and redirects the PC through a 16-entry absolute branch-target table when the decoder asserts `Branch` with its 4-bit `pc_immed`. Also provides start/done sequencing and cycle/instruction counters for the test bench.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/branch_lut.sv | 43 ++++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   // Width of the branch-target table index driven by the decoder.
   localparam int unsigned LUT_IDX_W = 4;

   // Default PC / instruction-ROM address width.
   localparam int unsigned PC_W_DFLT = 10;

   typedef logic [PC_W_DFLT-1:0] pc_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fetch_state_e;

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: LUT_N x PC_W register file, one write port, one
// combinational read port. A same-cycle write and read of one index returns
// the old value; the new value is visible from the next cycle.
module branch_lut
   import fetch_pkg::*;
#(
   parameter int unsigned LUT_N = 16,
   parameter int unsigned PC_W  = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [LUT_IDX_W-1:0] waddr,
   input  logic [PC_W-1:0]      wdata,
   input  logic [LUT_IDX_W-1:0] raddr,
   output logic [PC_W-1:0]      rdata
);

   logic [PC_W-1:0] mem_q [LUT_N];
   logic [PC_W-1:0] mem_d [LUT_N];

   // Next table contents: apply the single write port.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Table storage; reset clears every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LUT_N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Program counter and instruction-fetch stage. Drives the synchronous ROM
// with the next PC so a word is available every cycle, redirects through the
// branch-target table with no bubble, and sequences start/done with
// saturating cycle and instruction counters.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned IW    = 9,
   parameter int unsigned LUT_N = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PC_W-1:0]      last_pc,
   input  logic                 Branch,
   input  logic [LUT_IDX_W-1:0] pc_immed,
   input  logic                 lut_we,
   input  logic [LUT_IDX_W-1:0] lut_waddr,
   input  logic [PC_W-1:0]      lut_wdata,
   output logic [PC_W-1:0]      imem_addr,
   input  logic [IW-1:0]        imem_rdata,
   output logic [IW-1:0]        instr,
   output logic                 instr_valid,
   output logic [PC_W-1:0]      pc,
   output logic                 done,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic [CNT_W-1:0]     instr_cnt
);

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [PC_W-1:0]  lut_rdata;

   branch_lut #(
      .LUT_N (LUT_N),
      .PC_W  (PC_W)
   ) u_branch_lut (
      .clk   (clk),
      .reset (reset),
      .we    (lut_we),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (pc_immed),
      .rdata (lut_rdata)
   );

   // Next-state, next-PC and ROM address. imem_addr is 0 outside RUN so a
   // (re)start always finds word 0 already read out of the ROM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      imem_addr   = '0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               pc_d        = '0;
               cycle_cnt_d = '0;
               instr_cnt_d = '0;
            end
         end
         RUN: begin
            cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            instr_cnt_d = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);
            if (Branch) begin
               pc_d      = lut_rdata;
               imem_addr = lut_rdata;
            end else if (pc_q == last_pc) begin
               // Last instruction executes now; pc holds in DONE.
               state_d = DONE;
            end else begin
               pc_d      = pc_q + PC_W'(1);
               imem_addr = pc_q + PC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, PC and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign instr       = imem_rdata;
   assign instr_valid = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign pc          = pc_q;
   assign cycle_cnt   = cycle_cnt_q;
   assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stimulus, scored against a cycle-level behavioural model.
module tb_instr_fetch;

   localparam int PC_W  = 10;
   localparam int IW    = 9;
   localparam int CNT_W = 16;

   logic            clk;
   logic            reset;
   logic            start;
   logic [PC_W-1:0] last_pc;
   logic            Branch;
   logic [3:0]      pc_immed;
   logic            lut_we;
   logic [3:0]      lut_waddr;
   logic [PC_W-1:0] lut_wdata;
   logic [PC_W-1:0] imem_addr;
   logic [IW-1:0]   imem_rdata;
   logic [IW-1:0]   instr;
   logic            instr_valid;
   logic [PC_W-1:0] pc;
   logic            done;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;

   instr_fetch #(
      .PC_W  (PC_W),
      .IW    (IW),
      .LUT_N (16),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .last_pc     (last_pc),
      .Branch      (Branch),
      .pc_immed    (pc_immed),
      .lut_we      (lut_we),
      .lut_waddr   (lut_waddr),
      .lut_wdata   (lut_wdata),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .done        (done),
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM contents: a fixed scramble of the address.
   function automatic logic [IW-1:0] rom_word(input logic [PC_W-1:0] a);
      logic [PC_W-1:0] t;
      t = (a * 10'd37) ^ 10'h0a5;
      return t[IW-1:0];
   endfunction

   // Synchronous ROM, one-cycle read latency.
   always @(posedge clk) imem_rdata <= rom_word(imem_addr);

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [IW-1:0]    ins;
      logic [CNT_W-1:0] cc;
      logic [CNT_W-1:0] ic;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: what the block should look like in the current cycle.
   bit              m_run  = 0;
   bit              m_done = 0;
   logic [PC_W-1:0] m_pc   = '0;
   int              m_cyc  = 0;
   int              m_ins  = 0;
   logic [PC_W-1:0] m_lut [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid at pc %0d, expected none", pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("run_pc", 32'(pc), 32'(e.pc));
            chk("run_instr", 32'(instr), 32'(e.ins));
            chk("run_cycle_cnt", 32'(cycle_cnt), 32'(e.cc));
            chk("run_instr_cnt", 32'(instr_cnt), 32'(e.ic));
         end
      end
   end

   // One clock cycle: drive inputs, queue the expected output, advance model.
   task automatic step(input bit rst, input bit st, input bit br, input logic [3:0] imm,
                       input bit we, input logic [3:0] wa, input logic [PC_W-1:0] wd);
      bit              n_run, n_done;
      logic [PC_W-1:0] n_pc;
      int              n_cyc, n_ins;
      reset     = rst;
      start     = st;
      Branch    = br;
      pc_immed  = imm;
      lut_we    = we;
      lut_waddr = wa;
      lut_wdata = wd;
      if (m_run) exp_q.push_back('{m_pc, rom_word(m_pc), CNT_W'(m_cyc), CNT_W'(m_ins)});
      n_run  = m_run;
      n_done = m_done;
      n_pc   = m_pc;
      n_cyc  = m_cyc;
      n_ins  = m_ins;
      if (rst) begin
         n_run  = 0;
         n_done = 0;
         n_pc   = '0;
         n_cyc  = 0;
         n_ins  = 0;
         for (int i = 0; i < 16; i++) m_lut[i] = '0;
      end else begin
         if (m_run) begin
            n_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
            n_ins = (m_ins < 65535) ? m_ins + 1 : 65535;
            if (br) n_pc = m_lut[imm];
            else if (m_pc == last_pc) begin
               n_run  = 0;
               n_done = 1;
            end else n_pc = m_pc + 1'b1;
         end else if (st) begin
            n_run  = 1;
            n_done = 0;
            n_pc   = '0;
            n_cyc  = 0;
            n_ins  = 0;
         end
         if (we) m_lut[wa] = wd;
      end
      @(posedge clk);
      #1;
      m_run  = n_run;
      m_done = n_done;
      m_pc   = n_pc;
      m_cyc  = n_cyc;
      m_ins  = n_ins;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL missed_valid: got %0d unconsumed, expected 0", exp_q.size());
         exp_q.delete();
      end
      chk("done", 32'(done), 32'(m_done));
      if (!m_run) begin
         chk("valid_low", 32'(instr_valid), 32'd0);
         chk("hold_pc", 32'(pc), 32'(m_pc));
         chk("hold_cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
         chk("hold_instr_cnt", 32'(instr_cnt), 32'(m_ins));
      end
   endtask

   task automatic idle_step();
      step(0, 0, 0, 4'd0, 0, 4'd0, '0);
   endtask

   initial begin
      bit b;
      bit taken;
      for (int i = 0; i < 16; i++) m_lut[i] = '0;
      reset = 1'b1; start = 1'b0; Branch = 1'b0; pc_immed = '0;
      lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; last_pc = 10'd3;
      @(posedge clk);
      #1;
      step(1, 0, 0, 4'd0, 0, 4'd0, '0);
      step(1, 0, 0, 4'd0, 0, 4'd0, '0);

      // Straight-line run 0..3.
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      repeat (6) idle_step();
      chk("t1_cycle_cnt", 32'(cycle_cnt), 32'd4);
      chk("t1_instr_cnt", 32'(instr_cnt), 32'd4);

      // Branch at pc 2 through lut[5]=20, no bubble.
      step(0, 0, 0, 4'd0, 1, 4'd5, 10'd20);
      last_pc = 10'd22;
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 60; i++) begin
         if (m_done) break;
         step(0, 0, m_run && m_pc == 10'd2, 4'd5, 0, 4'd0, '0);
      end
      chk("t2_instr_cnt", 32'(instr_cnt), 32'd6);

      // Same-cycle write and branch on index 5 uses the old target.
      last_pc = 10'd31;
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 60; i++) begin
         if (m_done) break;
         b = m_run && (m_pc == 10'd2 || m_pc == 10'd21);
         step(0, 0, b, 4'd5, m_pc == 10'd2, 4'd5, 10'd30);
      end
      chk("t3_instr_cnt", 32'(instr_cnt), 32'd7);
      chk("t3_pc_hold", 32'(pc), 32'd31);

      // Taken branch at last_pc stays in RUN.
      step(0, 0, 0, 4'd0, 1, 4'd0, 10'd1);
      last_pc = 10'd3;
      taken = 0;
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 40; i++) begin
         if (m_done) break;
         b = m_run && m_pc == 10'd3 && !taken;
         if (b) taken = 1;
         step(0, 0, b, 4'd0, 0, 4'd0, '0);
      end
      chk("t4_instr_cnt", 32'(instr_cnt), 32'd7);

      // Reset mid-run clears everything, including the table.
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 10; i++) begin
         if (m_pc == 10'd2) break;
         idle_step();
      end
      step(1, 0, 0, 4'd0, 0, 4'd0, '0);
      chk("t5_pc", 32'(pc), 32'd0);
      chk("t5_cycle_cnt", 32'(cycle_cnt), 32'd0);
      taken = 0;
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 40; i++) begin
         if (m_done) break;
         b = m_run && m_pc == 10'd1 && !taken;
         if (b) taken = 1;
         step(0, 0, b, 4'd5, 0, 4'd0, '0);
      end
      chk("t5_instr_cnt", 32'(instr_cnt), 32'd6);

      // PC wraps 1023 -> 0; start mid-run is ignored.
      step(0, 0, 0, 4'd0, 1, 4'd1, 10'd1020);
      last_pc = 10'd2;
      taken = 0;
      step(0, 1, 0, 4'd0, 0, 4'd0, '0);
      for (int i = 0; i < 40; i++) begin
         if (m_done) break;
         b = m_run && m_pc == 10'd0 && !taken;
         if (b) taken = 1;
         step(0, m_pc == 10'd1021, b, 4'd1, 0, 4'd0, '0);
      end
      chk("t6_instr_cnt", 32'(instr_cnt), 32'd8);
      chk("t6_cycle_cnt", 32'(cycle_cnt), 32'd8);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 31) == 0) last_pc = PC_W'($urandom_range(0, 40));
         step($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
              PC_W'($urandom_range(0, 40)));
      end
      step(1, 0, 0, 4'd0, 0, 4'd0, '0);
      idle_step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
